// File: rtl/dcache_sb_pkg.sv
// Shared types for the L1 data cache store buffer.
//   sb_entry_t  : one buffered word {valid, word_addr, data, be}
//   sb_state_e  : drain FSM states
//   sb_merge()  : writes enabled byte lanes of a store into an entry
package dcache_sb_pkg;

    // Word addresses are stored at a fixed maximum width. The top zero-extends its
    // narrower address into this field, and the upper bits stay constant zero.
    localparam int unsigned SbWordAddrW = 61;

    typedef struct packed {
        logic                   valid;
        logic [SbWordAddrW-1:0] word_addr;
        logic [63:0]            data;
        logic [7:0]             be;
    } sb_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StTag
    } sb_state_e;

    function automatic sb_entry_t sb_merge(sb_entry_t e, logic [63:0] data, logic [7:0] be);
        sb_entry_t r;
        r = e;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) r.data[8*b +: 8] = data[8*b +: 8];
        end
        r.be = e.be | be;
        return r;
    endfunction

endpackage

// File: rtl/dcache_sb_match.sv
// Word-address comparator over all store buffer entries.
//   valid_i  : per-entry qualifier (entries that may match)
//   addr_i   : flattened per-entry word addresses, entry i at [i*AW +: AW]
//   key_i    : word address to look up
//   head_i   : oldest entry, used to order the youngest-match search
//   match_o  : per-entry match vector
//   any_o    : at least one entry matches
//   sel_o    : youngest matching entry (nearest the tail); head_i when none match
module dcache_sb_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 61,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]    valid_i,
    input  logic [DEPTH*AW-1:0] addr_i,
    input  logic [AW-1:0]       key_i,
    input  logic [PW-1:0]       head_i,
    output logic [DEPTH-1:0]    match_o,
    output logic                any_o,
    output logic [PW-1:0]       sel_o
);

    always_comb begin
        match_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match_o[i] = valid_i[i] && (addr_i[i*AW +: AW] == key_i);
        end
    end

    assign any_o = |match_o;

    // Valid entries are contiguous from the head, so walking oldest to youngest and
    // keeping the last hit yields the youngest match.
    always_comb begin
        sel_o = head_i;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (match_o[head_i + PW'(k)]) sel_o = head_i + PW'(k);
        end
    end

endmodule

// File: rtl/dcache_store_buffer.sv
// Coalescing store buffer feeding the L1 data cache store port.
//   st_*        : store unit handshake (valid/ready), byte address, data, byte enables
//   ld_addr_i / ld_match_o : load snoop against buffered words
//   data_req_o / data_gnt_i / address_index_o : cache index phase
//   tag_valid_o / address_tag_o : cache tag phase, always accepted
//   data_we_o / data_wdata_o / data_be_o : write data of the head entry
//   flush_i / flush_ack_o : drain-then-acknowledge flush handshake
//   empty_o     : no buffered entry and the drain FSM is idle
module dcache_store_buffer
    import dcache_sb_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned TAG_WIDTH   = 44
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         st_valid_i,
    output logic                         st_ready_o,
    input  logic [INDEX_WIDTH+TAG_WIDTH-1:0] st_addr_i,
    input  logic [63:0]                  st_data_i,
    input  logic [7:0]                   st_be_i,
    input  logic [INDEX_WIDTH+TAG_WIDTH-1:0] ld_addr_i,
    output logic                         ld_match_o,
    output logic                         data_req_o,
    input  logic                         data_gnt_i,
    output logic [INDEX_WIDTH-1:0]       address_index_o,
    output logic [TAG_WIDTH-1:0]         address_tag_o,
    output logic                         tag_valid_o,
    output logic                         data_we_o,
    output logic [63:0]                  data_wdata_o,
    output logic [7:0]                   data_be_o,
    input  logic                         flush_i,
    output logic                         flush_ack_o,
    output logic                         empty_o
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned AW  = INDEX_WIDTH + TAG_WIDTH;
    localparam int unsigned WAW = AW - 3;
    localparam logic [PW:0] DepthCnt = (PW+1)'(DEPTH);

    sb_entry_t        entries_q [DEPTH];
    sb_entry_t        entries_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    sb_state_e        state_q, state_d;
    logic             flush_acked_q, flush_acked_d;

    logic [DEPTH-1:0]             valid_vec, merge_valid_vec;
    logic [DEPTH*SbWordAddrW-1:0] addr_flat;
    logic [SbWordAddrW-1:0]       st_waddr, ld_waddr;
    logic                         merge_hit, ld_hit;
    logic [PW-1:0]                merge_sel;
    logic [DEPTH-1:0]             unused_merge_match, unused_ld_match_vec;
    logic [PW-1:0]                unused_ld_sel;
    logic                         unused_low_bits;
    logic                         st_ready, push, alloc, pop, empty;
    sb_entry_t                    head_e;

    assign st_waddr = SbWordAddrW'(st_addr_i[AW-1:3]);
    assign ld_waddr = SbWordAddrW'(ld_addr_i[AW-1:3]);
    assign unused_low_bits = ^{st_addr_i[2:0], ld_addr_i[2:0]};

    always_comb begin
        valid_vec = '0;
        addr_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries_q[i].valid;
            addr_flat[i*SbWordAddrW +: SbWordAddrW] = entries_q[i].word_addr;
        end
        // The head in its tag phase is already committed to the cache: never merge into it.
        merge_valid_vec = valid_vec;
        if (state_q == StTag) merge_valid_vec[head_q] = 1'b0;
    end

    dcache_sb_match #(
        .DEPTH (DEPTH),
        .AW    (SbWordAddrW)
    ) u_merge_match (
        .valid_i (merge_valid_vec),
        .addr_i  (addr_flat),
        .key_i   (st_waddr),
        .head_i  (head_q),
        .match_o (unused_merge_match),
        .any_o   (merge_hit),
        .sel_o   (merge_sel)
    );

    dcache_sb_match #(
        .DEPTH (DEPTH),
        .AW    (SbWordAddrW)
    ) u_ld_match (
        .valid_i (valid_vec),
        .addr_i  (addr_flat),
        .key_i   (ld_waddr),
        .head_i  (head_q),
        .match_o (unused_ld_match_vec),
        .any_o   (ld_hit),
        .sel_o   (unused_ld_sel)
    );

    // Ready ignores the slot freed by a same-cycle pop, so a full buffer only takes merges.
    assign st_ready = (count_q < DepthCnt) || merge_hit;
    assign push     = st_valid_i && st_ready;
    assign alloc    = push && !merge_hit;
    assign pop      = (state_q == StTag);
    assign empty    = (count_q == '0) && (state_q == StIdle);
    assign head_e   = entries_q[head_q];

    // Entry storage and pointers
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (push && merge_hit) begin
            entries_d[merge_sel] = sb_merge(entries_q[merge_sel], st_data_i, st_be_i);
        end else if (alloc) begin
            entries_d[tail_q].valid     = 1'b1;
            entries_d[tail_q].word_addr = st_waddr;
            entries_d[tail_q].data      = st_data_i;
            entries_d[tail_q].be        = st_be_i;
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d = head_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(alloc) - (PW+1)'(pop);
        flush_acked_d = flush_i && (flush_acked_q || flush_ack_o);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            flush_acked_q <= 1'b0;
        end else begin
            entries_q     <= entries_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            flush_acked_q <= flush_acked_d;
        end
    end

    // Drain FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Drain FSM: next state. Uses the post-push count so an accepted store requests next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_d != '0) state_d = StReq;
            StReq:   if (data_gnt_i) state_d = StTag;
            StTag:   state_d = (count_d != '0) ? StReq : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Drain FSM: outputs
    always_comb begin
        st_ready_o      = st_ready;
        ld_match_o      = ld_hit;
        data_req_o      = (state_q == StReq);
        tag_valid_o     = (state_q == StTag);
        data_we_o       = 1'b1;
        address_index_o = {head_e.word_addr[INDEX_WIDTH-4:0], 3'b000};
        address_tag_o   = head_e.word_addr[WAW-1:INDEX_WIDTH-3];
        data_wdata_o    = head_e.data;
        data_be_o       = head_e.be;
        empty_o         = empty;
        flush_ack_o     = flush_i && empty && !flush_acked_q;
    end

endmodule
